// File: rtl/s2mm_cmd_arbiter.sv
// Two-requester round-robin arbiter in front of a Data Mover S2MM command port.
// Tracks issued commands in an ID FIFO so each completion is routed back to its owner.
module s2mm_cmd_arbiter #(
    parameter int unsigned CMD_WIDTH = 72,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned CNT_WIDTH = 3
) (
    input  logic                 aclk,
    input  logic                 aresetn,

    input  logic [CMD_WIDTH-1:0] s0_cmd_tdata,
    input  logic                 s0_cmd_tvalid,
    output logic                 s0_cmd_tready,
    output logic                 s0_xfer_cmplt,

    input  logic [CMD_WIDTH-1:0] s1_cmd_tdata,
    input  logic                 s1_cmd_tvalid,
    output logic                 s1_cmd_tready,
    output logic                 s1_xfer_cmplt,

    output logic [CMD_WIDTH-1:0] m_axis_s2mm_cmd_tdata,
    output logic                 m_axis_s2mm_cmd_tvalid,
    input  logic                 m_axis_s2mm_cmd_tready,

    input  logic                 s2mm_wr_xfer_cmplt,
    output logic [CNT_WIDTH-1:0] outstanding_count,
    output logic                 grant_id,
    output logic                 cmplt_error
);

    localparam int unsigned PtrWidth = $clog2(MAX_OUTST);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e                 state_q;
    logic                   run_q;
    logic                   prio_q;
    logic                   grant_id_q;
    logic [CMD_WIDTH-1:0]   tdata_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic [PtrWidth-1:0]    wr_ptr_q;
    logic [PtrWidth-1:0]    rd_ptr_q;
    logic                   fifo_q [MAX_OUTST];
    logic                   s0_cmplt_q;
    logic                   s1_cmplt_q;
    logic                   err_q;

    logic can_grant;
    logic pick_s1;
    logic up_hs;
    logic dn_hs;
    logic pop;

    // run_q keeps both treadys low while reset is asserted, without using aresetn as data.
    always_comb begin
        can_grant     = run_q && (state_q == StIdle) && (count_q < CNT_WIDTH'(MAX_OUTST));
        pick_s1       = s1_cmd_tvalid && (!s0_cmd_tvalid || prio_q);
        s0_cmd_tready = can_grant && s0_cmd_tvalid && !pick_s1;
        s1_cmd_tready = can_grant && pick_s1;
        up_hs         = s0_cmd_tready || s1_cmd_tready;
        dn_hs         = (state_q == StIssue) && m_axis_s2mm_cmd_tready;
        pop           = s2mm_wr_xfer_cmplt && (count_q != '0);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            run_q      <= 1'b0;
            prio_q     <= 1'b0;
            grant_id_q <= 1'b0;
            tdata_q    <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            s0_cmplt_q <= 1'b0;
            s1_cmplt_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            s0_cmplt_q <= pop && !fifo_q[rd_ptr_q];
            s1_cmplt_q <= pop && fifo_q[rd_ptr_q];
            err_q      <= s2mm_wr_xfer_cmplt && (count_q == '0);

            case (state_q)
                StIdle: begin
                    if (up_hs) begin
                        state_q    <= StIssue;
                        tdata_q    <= pick_s1 ? s1_cmd_tdata : s0_cmd_tdata;
                        grant_id_q <= pick_s1;
                        prio_q     <= !pick_s1;
                    end
                end
                StIssue: begin
                    if (m_axis_s2mm_cmd_tready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (dn_hs) begin
                wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            end
            if (dn_hs && !pop) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end else if (pop && !dn_hs) begin
                count_q <= count_q - CNT_WIDTH'(1);
            end
        end
    end

    // ID storage needs no reset: entries are only read behind a nonzero count.
    always_ff @(posedge aclk) begin
        if (dn_hs) begin
            fifo_q[wr_ptr_q] <= grant_id_q;
        end
    end

    always_comb begin
        m_axis_s2mm_cmd_tdata  = tdata_q;
        m_axis_s2mm_cmd_tvalid = (state_q == StIssue);
        outstanding_count      = count_q;
        grant_id               = grant_id_q;
        s0_xfer_cmplt          = s0_cmplt_q;
        s1_xfer_cmplt          = s1_cmplt_q;
        cmplt_error            = err_q;
    end

endmodule
